ccff_bitstream_loader: RTL and testbench

- Serializes configuration words into one connection-block configuration chain.
- Sits directly upstream of the chain's `ccff_head`.
- Drives `ccff_head` plus a shift enable that gates the chain's programming clock, one bit per enabled cycle.
- Monitors the chain's `ccff_tail` during the load to detect stuck or mis-sized chains (after `pReset`, a healthy chain shifts out all zeros).

---
 rtl/ccff_bitstream_loader_if.sv | 49 ++++
 rtl/ccff_bitstream_loader.sv | 174 +++++++++++++++++
 tb/tb_ccff_bitstream_loader.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ccff_bitstream_loader_if.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader_if
//
// Purpose: bundles the word-input handshake, the load control/status lines
// and the serial connection to the configuration chain for
// ccff_bitstream_loader.
//
// Signals:
//   start         one-cycle pulse that begins a load
//   chk_en        sampled with start; enables the zero-readback check
//   word_in       configuration word, MSB shifted first
//   word_valid    word_in is valid
//   word_ready    loader accepts word_in on this edge
//   ccff_head     serial bit towards the chain head
//   ccff_shift_en chain shifts on an edge where this is 1
//   ccff_tail_in  bit leaving the chain tail
//   busy          load in progress
//   done          load completed (held until next start or reset)
//   error         sticky readback mismatch (held until next start or reset)
//
// Modports:
//   master  drives control, words and the chain tail (host + chain side)
//   slave   the loader itself
// ---------------------------------------------------------------------------
interface ccff_bitstream_loader_if #(
  parameter int WORD_W = 8
);
  logic              start;
  logic              chk_en;
  logic [WORD_W-1:0] word_in;
  logic              word_valid;
  logic              word_ready;
  logic              ccff_head;
  logic              ccff_shift_en;
  logic              ccff_tail_in;
  logic              busy;
  logic              done;
  logic              error;

  modport master (
    output start, chk_en, word_in, word_valid, ccff_tail_in,
    input  word_ready, ccff_head, ccff_shift_en, busy, done, error
  );

  modport slave (
    input  start, chk_en, word_in, word_valid, ccff_tail_in,
    output word_ready, ccff_head, ccff_shift_en, busy, done, error
  );
endinterface

// File: rtl/ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// ccff_bitstream_loader
//
// Purpose: serializes WORD_W-bit configuration words into a CHAIN_LEN-bit
// connection-block configuration chain. Words pass through one holding
// register into a shift register; bits leave MSB first on a registered
// ccff_head together with a registered shift enable that gates the chain's
// programming clock. While loading, the chain tail can be checked for the
// all-zero pattern a freshly reset chain shifts out.
//
// Ports:
//   prog_clk  programming clock (single domain)
//   pReset    asynchronous active-low reset
//   bus       ccff_bitstream_loader_if.slave (handshake, control, chain I/O)
// ---------------------------------------------------------------------------
module ccff_bitstream_loader #(
  parameter int WORD_W    = 8,
  parameter int CHAIN_LEN = 56,
  parameter int CNT_W     = 16
) (
  input  logic                      prog_clk,
  input  logic                      pReset,
  ccff_bitstream_loader_if.slave    bus
);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN, DONE} state_t;

  localparam int SH_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] NWORDS   = CNT_W'((CHAIN_LEN + WORD_W - 1) / WORD_W);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [SH_W-1:0]  SH_FULL  = SH_W'(WORD_W);
  localparam logic [SH_W-1:0]  SH_ONE   = SH_W'(1);

  state_t            state_q, state_d;
  logic              chkEn_q, chkEn_d;
  logic [WORD_W-1:0] hold_q, hold_d;
  logic              holdFull_q, holdFull_d;
  logic [WORD_W-1:0] sh_q, sh_d;
  logic [SH_W-1:0]   shCnt_q, shCnt_d;
  logic [CNT_W-1:0]  wordsAcc_q, wordsAcc_d;
  logic [CNT_W-1:0]  bitCnt_q, bitCnt_d;
  logic              head_q, head_d;
  logic              shiftEn_q, shiftEn_d;
  logic              error_q, error_d;

  logic wordReady;
  logic accept;
  logic issue;
  logic shEmptyNext;

  // Ready only while loading, with a free holding slot and words still owed.
  assign wordReady = (state_q == LOAD) && !holdFull_q && (wordsAcc_q < NWORDS);
  assign accept    = wordReady && bus.word_valid;
  assign issue     = (state_q == LOAD) && (shCnt_q != '0);
  // The shift register is either already empty or hands out its last bit now.
  assign shEmptyNext = (shCnt_q == '0) || (shCnt_q == SH_ONE);

  // State register; everything, including the serial outputs, clears on reset.
  always_ff @(posedge prog_clk or negedge pReset) begin
    if (!pReset) begin
      state_q    <= IDLE;
      chkEn_q    <= 1'b0;
      hold_q     <= '0;
      holdFull_q <= 1'b0;
      sh_q       <= '0;
      shCnt_q    <= '0;
      wordsAcc_q <= '0;
      bitCnt_q   <= '0;
      head_q     <= 1'b0;
      shiftEn_q  <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      chkEn_q    <= chkEn_d;
      hold_q     <= hold_d;
      holdFull_q <= holdFull_d;
      sh_q       <= sh_d;
      shCnt_q    <= shCnt_d;
      wordsAcc_q <= wordsAcc_d;
      bitCnt_q   <= bitCnt_d;
      head_q     <= head_d;
      shiftEn_q  <= shiftEn_d;
      error_q    <= error_d;
    end
  end

  // Next-state logic: start handling, bit issue, word buffering and the
  // tail readback check. Shift enable is low unless a bit is issued.
  always_comb begin
    state_d    = state_q;
    chkEn_d    = chkEn_q;
    hold_d     = hold_q;
    holdFull_d = holdFull_q;
    sh_d       = sh_q;
    shCnt_d    = shCnt_q;
    wordsAcc_d = wordsAcc_q;
    bitCnt_d   = bitCnt_q;
    head_d     = head_q;
    shiftEn_d  = 1'b0;
    error_d    = error_q;

    // The chain shifts on every edge where the enable is high, so that is
    // exactly when a new bit appears at its tail.
    if (shiftEn_q && chkEn_q && bus.ccff_tail_in) begin
      error_d = 1'b1;
    end

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d    = LOAD;
          chkEn_d    = bus.chk_en;
          error_d    = 1'b0;
          holdFull_d = 1'b0;
          shCnt_d    = '0;
          wordsAcc_d = '0;
          bitCnt_d   = '0;
        end
      end

      LOAD: begin
        if (issue) begin
          head_d    = sh_q[WORD_W-1];
          shiftEn_d = 1'b1;
          bitCnt_d  = bitCnt_q + CNT_W'(1);
          sh_d      = sh_q << 1;
          shCnt_d   = shCnt_q - SH_ONE;
        end

        if (issue && (bitCnt_q == LAST_IDX)) begin
          // Final chain bit: any low-order leftovers of the last word are dropped.
          state_d    = DRAIN;
          shCnt_d    = '0;
          holdFull_d = 1'b0;
        end else if (shEmptyNext) begin
          // Refill the shift register in the same edge so no bubble appears;
          // with an empty holding slot a fresh word goes straight in.
          if (holdFull_q) begin
            sh_d       = hold_q;
            shCnt_d    = SH_FULL;
            holdFull_d = 1'b0;
          end else if (accept) begin
            sh_d    = bus.word_in;
            shCnt_d = SH_FULL;
          end
        end else if (accept) begin
          hold_d     = bus.word_in;
          holdFull_d = 1'b1;
        end

        if (accept) begin
          wordsAcc_d = wordsAcc_q + CNT_W'(1);
        end
      end

      DRAIN: begin
        // The last enabled cycle; its tail sample is taken on this edge.
        state_d = DONE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.word_ready    = wordReady;
  assign bus.ccff_head     = head_q;
  assign bus.ccff_shift_en = shiftEn_q;
  assign bus.busy          = (state_q == LOAD) || (state_q == DRAIN);
  assign bus.done          = (state_q == DONE);
  assign bus.error         = error_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// ---------------------------------------------------------------------------
// tb_ccff_bitstream_loader
//
// Purpose: self-checking bench for ccff_bitstream_loader. Two loaders are
// instantiated: A with the default 56-bit chain and B with a 20-bit chain to
// exercise the partial last word. Expected chain bits are queued when a
// word is presented; per-loader monitors pop and compare on every enabled
// shift cycle.
// ---------------------------------------------------------------------------
module tb_ccff_bitstream_loader;

  typedef logic [7:0] wordArr_t [8];

  logic prog_clk = 1'b0;
  logic pReset   = 1'b0;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader_if #(.WORD_W(8)) busA ();
  ccff_bitstream_loader_if #(.WORD_W(8)) busB ();

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(56), .CNT_W(16)) dutA (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (busA.slave)
  );

  ccff_bitstream_loader #(.WORD_W(8), .CHAIN_LEN(20), .CNT_W(16)) dutB (
    .prog_clk (prog_clk),
    .pReset   (pReset),
    .bus      (busB.slave)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bit expQA[$];
  bit expQB[$];

  // Load bookkeeping: the stimulus bumps loadId, the monitors restart their
  // per-load counters when they see a new id.
  int loadIdA = 0, seenIdA = 0, loadIdB = 0, seenIdB = 0;
  int shiftCntA = 0, firstCycA = 0, lastCycA = 0;
  int shiftCntB = 0, firstCycB = 0, lastCycB = 0;
  int faultAt = 0;
  logic errAt30 = 1'b0, errAt31 = 1'b0;
  logic expBitA, expBitB;

  int acceptCyc, doneCyc, accepted;

  always @(posedge prog_clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor A: scoreboard pop on each enabled cycle plus tail fault injection.
  always @(negedge prog_clk) begin
    if (pReset && busA.ccff_shift_en) begin
      if (loadIdA != seenIdA) begin
        seenIdA   = loadIdA;
        shiftCntA = 0;
      end
      shiftCntA++;
      if (shiftCntA == 1) firstCycA = cyc;
      lastCycA = cyc;
      if (expQA.size() == 0) begin
        checkOutput("headA_unexpected_shift", 32'(shiftCntA), 32'(0));
      end else begin
        expBitA = expQA.pop_front();
        checkOutput("headA_bit", 32'(busA.ccff_head), 32'(expBitA));
      end
      if (faultAt != 0 && shiftCntA == faultAt) errAt30 = busA.error;
      if (faultAt != 0 && shiftCntA == faultAt + 1) errAt31 = busA.error;
    end
    busA.ccff_tail_in = pReset && busA.ccff_shift_en && (faultAt != 0) && (shiftCntA == faultAt);
  end

  // Monitor B: scoreboard pop only, tail is held at 0.
  always @(negedge prog_clk) begin
    if (pReset && busB.ccff_shift_en) begin
      if (loadIdB != seenIdB) begin
        seenIdB   = loadIdB;
        shiftCntB = 0;
      end
      shiftCntB++;
      if (shiftCntB == 1) firstCycB = cyc;
      lastCycB = cyc;
      if (expQB.size() == 0) begin
        checkOutput("headB_unexpected_shift", 32'(shiftCntB), 32'(0));
      end else begin
        expBitB = expQB.pop_front();
        checkOutput("headB_bit", 32'(busB.ccff_head), 32'(expBitB));
      end
    end
  end

  task automatic setInputs(input int sel, input logic st, input logic ck, input logic vl, input logic [7:0] w);
    if (sel == 0) begin
      busA.start = st; busA.chk_en = ck; busA.word_valid = vl; busA.word_in = w;
    end else begin
      busB.start = st; busB.chk_en = ck; busB.word_valid = vl; busB.word_in = w;
    end
  endtask

  function automatic logic readyOf(input int sel);
    return (sel == 0) ? busA.word_ready : busB.word_ready;
  endfunction

  function automatic logic doneOf(input int sel);
    return (sel == 0) ? busA.done : busB.done;
  endfunction

  function automatic logic busyOf(input int sel);
    return (sel == 0) ? busA.busy : busB.busy;
  endfunction

  // One load: start pulse, then nWords words spaced by gap cycles.
  // midStart>0 pulses start after that many acceptances; abortAt>0 returns
  // once that many shifts are seen instead of waiting for done.
  task automatic applyStimulus(input int sel, input logic chk, input int gap, input int nWords,
                               input wordArr_t words, input int chainLen,
                               input int midStart, input int abortAt);
    int pushed;
    bit ok;
    pushed   = 0;
    accepted = 0;
    if (sel == 0) loadIdA++; else loadIdB++;
    @(posedge prog_clk); #1;
    setInputs(sel, 1'b1, chk, 1'b0, 8'h00);
    @(posedge prog_clk); #1;
    setInputs(sel, 1'b0, chk, 1'b0, 8'h00);
    for (int i = 0; i < nWords; i++) begin
      if (gap > 0 && i > 0) begin
        repeat (gap - 1) @(posedge prog_clk);
        #1;
      end
      setInputs(sel, 1'b0, chk, 1'b1, words[i]);
      for (int b = 7; b >= 0; b--) begin
        if (pushed < chainLen) begin
          if (sel == 0) expQA.push_back(words[i][b]); else expQB.push_back(words[i][b]);
          pushed++;
        end
      end
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
        @(negedge prog_clk);
        if (readyOf(sel)) begin ok = 1'b1; break; end
      end
      if (!ok) begin
        checkOutput("word_accept_timeout", 32'(i), 32'(-1));
        setInputs(sel, 1'b0, chk, 1'b0, 8'h00);
        return;
      end
      @(posedge prog_clk); #1;
      if (i == 0) acceptCyc = cyc;
      accepted++;
      setInputs(sel, 1'b0, chk, 1'b0, 8'h00);
      if (midStart == i + 1) begin
        setInputs(sel, 1'b1, chk, 1'b0, 8'h00);
        @(posedge prog_clk); #1;
        setInputs(sel, 1'b0, chk, 1'b0, 8'h00);
        checkOutput("busy_after_mid_start", 32'(busyOf(sel)), 32'(1));
      end
    end
    if (abortAt > 0) begin
      for (int t = 0; t < 200 && shiftCntA < abortAt; t++) @(negedge prog_clk);
      checkOutput("abort_point_shifts", 32'(shiftCntA), 32'(abortAt));
      return;
    end
    @(negedge prog_clk);
    checkOutput("word_ready_after_last", 32'(readyOf(sel)), 32'(0));
    ok = 1'b0;
    for (int t = 0; t < 300; t++) begin
      if (doneOf(sel)) begin ok = 1'b1; break; end
      @(negedge prog_clk);
    end
    checkOutput("done_reached", 32'(ok), 32'(1));
    doneCyc = cyc;
  endtask

  task automatic checkResetOutputs(input string tag);
    checkOutput({tag, "_busy"},     32'(busA.busy),          32'(0));
    checkOutput({tag, "_done"},     32'(busA.done),          32'(0));
    checkOutput({tag, "_error"},    32'(busA.error),         32'(0));
    checkOutput({tag, "_ready"},    32'(busA.word_ready),    32'(0));
    checkOutput({tag, "_shift_en"}, 32'(busA.ccff_shift_en), 32'(0));
    checkOutput({tag, "_head"},     32'(busA.ccff_head),     32'(0));
  endtask

  task automatic checkFullLoad(input string tag, input logic expErr);
    checkOutput({tag, "_shift_count"}, 32'(shiftCntA),          32'(56));
    checkOutput({tag, "_queue_left"},  32'(expQA.size()),       32'(0));
    checkOutput({tag, "_error"},       32'(busA.error),         32'(expErr));
    checkOutput({tag, "_busy"},        32'(busA.busy),          32'(0));
    checkOutput({tag, "_done_delay"},  32'(doneCyc - lastCycA), 32'(1));
    checkOutput({tag, "_accepted"},    32'(accepted),           32'(7));
  endtask

  wordArr_t wordsA = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E, 8'h5A, 8'h00};
  wordArr_t wordsB = '{8'hF0, 8'h0F, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

  initial begin
    setInputs(0, 1'b0, 1'b0, 1'b0, 8'h00);
    setInputs(1, 1'b0, 1'b0, 1'b0, 8'h00);
    busB.ccff_tail_in = 1'b0;
    pReset = 1'b0;
    repeat (3) @(negedge prog_clk);
    checkResetOutputs("reset");
    pReset = 1'b1;

    // Full back-to-back load with readback check enabled.
    applyStimulus(0, 1'b1, 0, 7, wordsA, 56, 0, 0);
    checkFullLoad("full", 1'b0);
    checkOutput("full_contiguous_span", 32'(lastCycA - firstCycA + 1), 32'(56));
    checkOutput("full_first_bit_latency", 32'(firstCycA - acceptCyc), 32'(1));

    // Words only every 12 cycles: bubbles appear, bit order unchanged.
    applyStimulus(0, 1'b1, 12, 7, wordsA, 56, 0, 0);
    checkFullLoad("bubble", 1'b0);
    checkOutput("bubble_gaps_seen", 32'((lastCycA - firstCycA + 1) > 56), 32'(1));

    // 20-bit chain: last word only partly shifted.
    applyStimulus(1, 1'b1, 0, 3, wordsB, 20, 0, 0);
    checkOutput("partial_shift_count", 32'(shiftCntB),    32'(20));
    checkOutput("partial_queue_left",  32'(expQB.size()), 32'(0));
    checkOutput("partial_accepted",    32'(accepted),     32'(3));
    checkOutput("partial_done",        32'(busB.done),    32'(1));
    checkOutput("partial_error",       32'(busB.error),   32'(0));

    // Tail forced high on shift 30 with checking enabled.
    faultAt = 30;
    applyStimulus(0, 1'b1, 0, 7, wordsA, 56, 0, 0);
    checkFullLoad("fault", 1'b1);
    checkOutput("fault_error_before", 32'(errAt30), 32'(0));
    checkOutput("fault_error_after",  32'(errAt31), 32'(1));
    checkOutput("fault_done",         32'(busA.done), 32'(1));

    // Same fault with checking disabled.
    applyStimulus(0, 1'b0, 0, 7, wordsA, 56, 0, 0);
    checkFullLoad("nochk", 1'b0);
    faultAt = 0;

    // Reset after 25 shifts, then a clean load.
    applyStimulus(0, 1'b1, 0, 4, wordsA, 56, 0, 25);
    #2 pReset = 1'b0;
    #1 checkResetOutputs("midreset");
    expQA.delete();
    repeat (4) @(negedge prog_clk);
    checkOutput("midreset_no_done", 32'(busA.done), 32'(0));
    pReset = 1'b1;
    applyStimulus(0, 1'b1, 0, 7, wordsA, 56, 0, 0);
    checkFullLoad("restart", 1'b0);
    checkOutput("restart_contiguous_span", 32'(lastCycA - firstCycA + 1), 32'(56));

    // Start pulse in the middle of a load is ignored.
    applyStimulus(0, 1'b1, 0, 7, wordsA, 56, 3, 0);
    checkFullLoad("midstart", 1'b0);
    checkOutput("midstart_done", 32'(busA.done), 32'(1));

    repeat (2) @(negedge prog_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
